bcd_score_display: RTL

- Parametrised, sequential binary-to-BCD converter with a 7-segment output stage. It drives the score digits on the HEX displays.
- It converts a BIN_W-bit unsigned value into DIGITS decimal digits, one input bit per clock, using the shift-and-add-3 (double-dabble) method.
- It adds features beyond a purely combinational score decoder: a start/valid handshake, overflow saturation, a configurable clear code and optional leading-zero blanking.
- Outputs are registered and hold their value between conversions.

---
 rtl/display_pkg.sv | 21 ++
 rtl/seg7_hex_decoder.sv | 32 +++
 rtl/bcd_score_display.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the score display converter.
//   state_t     : converter FSM states
//   SEG_BLANK   : active-low pattern with every segment off
//   BCD_NINE    : digit value used when the result saturates
//   add3_digit  : double-dabble digit correction (add 3 when >= 5)
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_NINE  = 4'h9;

  function automatic logic [3:0] add3_digit(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
//   bcd : 4-bit digit value (0-F)
//   seg : segments {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_hex_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (bcd)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/bcd_score_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with registered 7-segment outputs for the score digits.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one input bit shifted into the BCD scratch per cycle
// DONE  | results registered, valid high for this cycle; start accepted
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : conversion request, accepted when busy=0
//   bin_in     : unsigned value to convert, sampled with start
//   blank_lz   : leading-zero blanking enable, sampled with start
//   busy       : conversion in progress
//   valid      : one-cycle pulse marking a new result
//   bcd_out    : BCD digits, most significant digit in the top nibble
//   hex_out    : active-low segments, digit k at [7k+6:7k]
//   overflow   : last value did not fit in DIGITS decimal digits
module bcd_score_display
  import display_pkg::*;
#(
  parameter int BIN_W      = 8,
  parameter int DIGITS     = 3,
  parameter int CLEAR_EN   = 1,
  parameter int CLEAR_CODE = 251
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  overflow
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [SW-1:0]      scratch;
  logic [BIN_W-1:0]   bin_sh;
  logic [BIN_W-1:0]   bin_lat;
  logic               blank_lat;
  logic               ovf_sticky;
  logic [CNT_W-1:0]   bit_cnt;

  logic [SW-1:0]      scratch_adj;
  logic [SW-1:0]      scratch_nxt;
  logic [BIN_W-1:0]   bin_nxt;
  logic               ovf_nxt;
  logic               is_clear;
  logic [SW-1:0]      bcd_res;
  logic               ovf_res;
  logic [6:0]         seg_raw [DIGITS];
  logic [7*DIGITS-1:0] hex_res;

  // One double-dabble step. The bit leaving the top digit has nowhere to
  // go, so it becomes the sticky overflow indication.
  always_comb begin
    scratch_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      scratch_adj[4*k +: 4] = add3_digit(scratch[4*k +: 4]);
    end
    {scratch_nxt, bin_nxt} = {scratch_adj[SW-2:0], bin_sh, 1'b0};
    ovf_nxt = ovf_sticky | scratch_adj[SW-1];
  end

  // Result selection, evaluated on the final shift so the outputs register
  // together with the transition into DONE.
  always_comb begin
    is_clear = (CLEAR_EN != 0) && (bin_lat == BIN_W'(CLEAR_CODE));
    bcd_res  = scratch_nxt;
    ovf_res  = 1'b0;
    if (is_clear) begin
      bcd_res = '0;
    end else if (ovf_nxt) begin
      bcd_res = {DIGITS{BCD_NINE}};
      ovf_res = 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      seg7_hex_decoder u_dec (
        .bcd (bcd_res[4*g +: 4]),
        .seg (seg_raw[g])
      );
    end
  endgenerate

  // Walk down from the top digit; blank zeros until the first nonzero one.
  always_comb begin
    logic leading;
    leading = blank_lat;
    hex_res = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (leading && (bcd_res[4*k +: 4] == 4'd0)) begin
        hex_res[7*k +: 7] = SEG_BLANK;
      end else begin
        hex_res[7*k +: 7] = seg_raw[k];
        leading = 1'b0;
      end
    end
    hex_res[6:0] = seg_raw[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
      bcd_out    <= '0;
      hex_out    <= '1;
      scratch    <= '0;
      bin_sh     <= '0;
      bin_lat    <= '0;
      blank_lat  <= 1'b0;
      ovf_sticky <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bin_sh     <= bin_in;
            bin_lat    <= bin_in;
            blank_lat  <= blank_lz;
            scratch    <= '0;
            bit_cnt    <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch    <= scratch_nxt;
          bin_sh     <= bin_nxt;
          ovf_sticky <= ovf_nxt;
          bit_cnt    <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(BIN_W - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            valid    <= 1'b1;
            bcd_out  <= bcd_res;
            hex_out  <= hex_res;
            overflow <= ovf_res;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
